// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates at dispatch, captures CDB results,
// and retires the completed head entry as a registered one-cycle retire packet.
module reorder_buffer #(
    parameter int  ROB_SZ = 8,
    parameter int  XLEN   = 32,
    localparam int TAG_W  = $clog2(ROB_SZ)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             squash,
    input  logic             dp_valid,
    input  logic [4:0]       dp_r,
    output logic             dp_ready,
    output logic [TAG_W-1:0] dp_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_value,
    output logic             rt_valid,
    output logic             rt_complete,
    output logic [4:0]       rt_r,
    output logic [XLEN-1:0]  rt_V,
    output logic [TAG_W-1:0] rt_tag,
    output logic [TAG_W:0]   rob_count
);

    localparam logic [TAG_W:0]   FULL_CNT = (TAG_W + 1)'(ROB_SZ);
    localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W + 1)'(1);
    localparam logic [TAG_W-1:0] PTR_ONE  = TAG_W'(1);

    logic [ROB_SZ-1:0] valid_q, valid_d;
    logic [ROB_SZ-1:0] complete_q, complete_d;
    logic [4:0]        r_q [ROB_SZ];
    logic [4:0]        r_d [ROB_SZ];
    logic [XLEN-1:0]   v_q [ROB_SZ];
    logic [XLEN-1:0]   v_d [ROB_SZ];

    logic [TAG_W-1:0]  head_q, head_d;
    logic [TAG_W-1:0]  tail_q, tail_d;
    logic [TAG_W:0]    count_q, count_d;

    logic              rt_valid_q, rt_valid_d;
    logic [4:0]        rt_r_q, rt_r_d;
    logic [XLEN-1:0]   rt_v_q, rt_v_d;
    logic [TAG_W-1:0]  rt_tag_q, rt_tag_d;

    logic              dispatch_accept;
    logic              retire;
    logic              cdb_hit;

    // Full is judged by the registered count only, so a same-cycle retire never frees a slot.
    assign dp_ready = (count_q != FULL_CNT);
    assign dp_tag   = tail_q;

    always_comb begin
        dispatch_accept = dp_valid && dp_ready;
        retire          = (count_q != '0) && complete_q[head_q];
        cdb_hit         = cdb_valid && valid_q[cdb_tag] && !complete_q[cdb_tag];

        valid_d    = valid_q;
        complete_d = complete_q;
        r_d        = r_q;
        v_d        = v_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        rt_valid_d = 1'b0;
        rt_r_d     = rt_r_q;
        rt_v_d     = rt_v_q;
        rt_tag_d   = rt_tag_q;

        if (squash) begin
            valid_d    = '0;
            complete_d = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (cdb_hit) begin
                complete_d[cdb_tag] = 1'b1;
                v_d[cdb_tag]        = cdb_value;
            end

            if (retire) begin
                valid_d[head_q]    = 1'b0;
                complete_d[head_q] = 1'b0;
                head_d             = head_q + PTR_ONE;
                rt_valid_d         = 1'b1;
                rt_r_d             = r_q[head_q];
                rt_v_d             = v_q[head_q];
                rt_tag_d           = head_q;
            end

            // tail never equals head while retiring: that would need count 0 or a full buffer.
            if (dispatch_accept) begin
                valid_d[tail_q]    = 1'b1;
                complete_d[tail_q] = 1'b0;
                r_d[tail_q]        = dp_r;
                v_d[tail_q]        = '0;
                tail_d             = tail_q + PTR_ONE;
            end

            unique case ({dispatch_accept, retire})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q    <= '0;
            complete_q <= '0;
            for (int i = 0; i < ROB_SZ; i++) begin
                r_q[i] <= '0;
                v_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rt_valid_q <= 1'b0;
            rt_r_q     <= '0;
            rt_v_q     <= '0;
            rt_tag_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            complete_q <= complete_d;
            for (int i = 0; i < ROB_SZ; i++) begin
                r_q[i] <= r_d[i];
                v_q[i] <= v_d[i];
            end
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rt_valid_q <= rt_valid_d;
            rt_r_q     <= rt_r_d;
            rt_v_q     <= rt_v_d;
            rt_tag_q   <= rt_tag_d;
        end
    end

    assign rt_valid    = rt_valid_q;
    assign rt_complete = rt_valid_q;
    assign rt_r        = rt_r_q;
    assign rt_V        = rt_v_q;
    assign rt_tag      = rt_tag_q;
    assign rob_count   = count_q;

    a_count_bound: assert property (@(posedge clock) disable iff (reset) count_q <= FULL_CNT);

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: in-order retire, full refusal, wrap-around,
// CDB-to-head latency, squash and asynchronous reset.
module tb_reorder_buffer;

    localparam int ROB_SZ = 8;
    localparam int XLEN   = 32;
    localparam int TAG_W  = 3;

    logic             clock;
    logic             reset;
    logic             squash;
    logic             dp_valid;
    logic [4:0]       dp_r;
    logic             dp_ready;
    logic [TAG_W-1:0] dp_tag;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_value;
    logic             rt_valid;
    logic             rt_complete;
    logic [4:0]       rt_r;
    logic [XLEN-1:0]  rt_V;
    logic [TAG_W-1:0] rt_tag;
    logic [TAG_W:0]   rob_count;

    int n_checks;
    int n_errors;

    // Scoreboard entries are {tag, r, V} in dispatch order.
    logic [39:0]      exp_q[$];
    logic [2:0]       pend_q[$];
    logic [39:0]      exp_item;

    int               seq;
    int               cyc;
    int               cnt_m;
    int               max_obs;
    logic [2:0]       head_m;
    logic [2:0]       tail_m;
    logic [7:0]       comp_m;
    logic [31:0]      val_m [8];
    logic             dv_m;
    logic             acc_m;
    logic             cv_m;
    logic             ret_m;
    logic [2:0]       ct_m;
    logic [4:0]       r_now;

    reorder_buffer #(.ROB_SZ(ROB_SZ), .XLEN(XLEN)) dut (
        .clock       (clock),
        .reset       (reset),
        .squash      (squash),
        .dp_valid    (dp_valid),
        .dp_r        (dp_r),
        .dp_ready    (dp_ready),
        .dp_tag      (dp_tag),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_value   (cdb_value),
        .rt_valid    (rt_valid),
        .rt_complete (rt_complete),
        .rt_r        (rt_r),
        .rt_V        (rt_V),
        .rt_tag      (rt_tag),
        .rob_count   (rob_count)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Driver tasks
    task automatic idle_inputs();
        squash    = 1'b0;
        dp_valid  = 1'b0;
        dp_r      = '0;
        cdb_valid = 1'b0;
        cdb_tag   = '0;
        cdb_value = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic dv, input logic [4:0] r, input logic cv,
                         input logic [2:0] ct, input logic [31:0] cval);
        dp_valid  = dv;
        dp_r      = r;
        cdb_valid = cv;
        cdb_tag   = ct;
        cdb_value = cval;
        tick();
        idle_inputs();
    endtask

    task automatic pulse_async_reset();
        #2 reset = 1'b1;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_count", rob_count, 0);
        check("rst_ready", dp_ready, 1);
        check("rst_dp_tag", dp_tag, 0);
        check("rst_rt_valid", rt_valid, 0);
        check("rst_rt_complete", rt_complete, 0);
        check("rst_rt_pkt", {rt_tag, rt_r, rt_V}, 40'h0);
        @(negedge clock) reset = 1'b0;

        // In-order retire with out-of-order completion
        drive(1, 5'd3, 0, 0, 0);
        check("t2_count1", rob_count, 1);
        check("t2_dp_tag1", dp_tag, 1);
        drive(1, 5'd7, 0, 0, 0);
        check("t2_count2", rob_count, 2);
        drive(0, 0, 1, 3'd1, 32'hBEEF);
        check("t2_no_retire_a", rt_valid, 0);
        drive(0, 0, 1, 3'd0, 32'h1234);
        check("t2_no_bypass", rt_valid, 0);
        drive(0, 0, 0, 0, 0);
        check("t2_rt0_valid", rt_valid, 1);
        check("t2_rt0_complete", rt_complete, 1);
        check("t2_rt0_pkt", {rt_tag, rt_r, rt_V}, {3'd0, 5'd3, 32'h1234});
        check("t2_count_after0", rob_count, 1);
        drive(0, 0, 0, 0, 0);
        check("t2_rt1_valid", rt_valid, 1);
        check("t2_rt1_pkt", {rt_tag, rt_r, rt_V}, {3'd1, 5'd7, 32'hBEEF});
        check("t2_count_after1", rob_count, 0);
        drive(0, 0, 0, 0, 0);
        check("t2_rt_drop", rt_valid, 0);
        check("t2_rt_hold", {rt_tag, rt_r, rt_V}, {3'd1, 5'd7, 32'hBEEF});

        // Fill to full; dispatch refused even with a same-cycle retire
        for (int i = 0; i < 8; i++) drive(1, 5'(i + 1), 0, 0, 0);
        check("t3_full_count", rob_count, 8);
        check("t3_full_ready", dp_ready, 0);
        drive(0, 0, 1, 3'd2, 32'hC0DE);
        check("t3_no_retire", rt_valid, 0);
        drive(1, 5'd31, 0, 0, 0);
        check("t3_refused_count", rob_count, 7);
        check("t3_rt_valid", rt_valid, 1);
        check("t3_rt_pkt", {rt_tag, rt_r, rt_V}, {3'd2, 5'd1, 32'hC0DE});
        check("t3_tail_unmoved", dp_tag, 2);
        check("t3_ready_again", dp_ready, 1);

        pulse_async_reset();
        check("t3_arst_count", rob_count, 0);
        check("t3_arst_rt_valid", rt_valid, 0);
        check("t3_arst_dp_tag", dp_tag, 0);
        @(negedge clock) reset = 1'b0;

        // Asynchronous reset with 5 live entries
        for (int i = 0; i < 5; i++) drive(1, 5'(10 + i), 0, 0, 0);
        check("t1_live_count", rob_count, 5);
        pulse_async_reset();
        check("t1_arst_count", rob_count, 0);
        check("t1_arst_ready", dp_ready, 1);
        check("t1_arst_rt_valid", rt_valid, 0);
        check("t1_arst_dp_tag", dp_tag, 0);
        @(negedge clock) reset = 1'b0;

        // CDB to head: retire two cycles later; duplicate and invalid-tag CDBs ignored
        drive(1, 5'd9, 0, 0, 0);
        drive(0, 0, 1, 3'd0, 32'h55);
        check("t5_n1_no_retire", rt_valid, 0);
        drive(0, 0, 1, 3'd0, 32'h66);
        check("t5_n2_retire", rt_valid, 1);
        check("t5_pkt", {rt_tag, rt_r, rt_V}, {3'd0, 5'd9, 32'h55});
        check("t5_count", rob_count, 0);
        drive(0, 0, 1, 3'd3, 32'h77);
        check("t5_invalid_cdb", rt_valid, 0);
        check("t5_invalid_count", rob_count, 0);
        drive(0, 0, 0, 0, 0);
        check("t5_still_idle", rt_valid, 0);
        check("t5_hold_v", rt_V, 32'h55);

        // 20-instruction wrap-around run against the scoreboard
        seq = 0; cyc = 0; cnt_m = 0; max_obs = 0;
        head_m = 3'd1; tail_m = 3'd1; comp_m = '0;
        for (int i = 0; i < 8; i++) val_m[i] = '0;
        while (!(seq == 20 && cnt_m == 0) && cyc < 200) begin
            dv_m  = (seq < 20);
            acc_m = dv_m && (cnt_m != 8);
            check("t4_ready", dp_ready, (cnt_m != 8));
            check("t4_dp_tag", dp_tag, tail_m);
            cv_m = 1'b0;
            ct_m = '0;
            if (pend_q.size() > 0 && (cyc % 2 == 0 || seq >= 20)) begin
                cv_m = 1'b1;
                ct_m = (cyc % 4 == 0) ? pend_q.pop_back() : pend_q.pop_front();
            end
            ret_m = (cnt_m != 0) && comp_m[head_m];
            r_now = 5'((seq * 7 + 1) % 32);
            dp_valid  = dv_m;
            dp_r      = r_now;
            cdb_valid = cv_m;
            cdb_tag   = ct_m;
            cdb_value = val_m[ct_m];
            tick();
            idle_inputs();
            if (cv_m) comp_m[ct_m] = 1'b1;
            if (ret_m) begin
                comp_m[head_m] = 1'b0;
                head_m = head_m + 3'd1;
            end
            if (acc_m) begin
                val_m[tail_m]  = 32'hA000_0000 + 32'(seq);
                comp_m[tail_m] = 1'b0;
                exp_q.push_back({tail_m, r_now, val_m[tail_m]});
                pend_q.push_back(tail_m);
                tail_m = tail_m + 3'd1;
                seq++;
            end
            cnt_m = cnt_m + int'(acc_m) - int'(ret_m);
            check("t4_count", rob_count, cnt_m);
            check("t4_rt_valid", rt_valid, ret_m);
            if (ret_m && exp_q.size() > 0) begin
                exp_item = exp_q.pop_front();
                check("t4_rt_pkt", {rt_tag, rt_r, rt_V}, exp_item);
            end
            if (int'(rob_count) > max_obs) max_obs = int'(rob_count);
            cyc++;
        end
        check("t4_no_timeout", (cyc < 200), 1);
        check("t4_reached_full", max_obs, 8);
        check("t4_sb_empty", exp_q.size(), 0);
        check("t4_drained", rob_count, 0);

        // Squash with 4 live entries plus a pending dispatch, CDB and retire
        for (int i = 0; i < 3; i++) drive(1, 5'(20 + i), 0, 0, 0);
        drive(1, 5'd23, 1, 3'd5, 32'h99);
        check("t6_live_count", rob_count, 4);
        squash    = 1'b1;
        dp_valid  = 1'b1;
        dp_r      = 5'd1;
        cdb_valid = 1'b1;
        cdb_tag   = 3'd6;
        cdb_value = 32'hDEAD;
        tick();
        idle_inputs();
        check("t6_count", rob_count, 0);
        check("t6_rt_valid", rt_valid, 0);
        check("t6_dp_tag", dp_tag, 0);
        check("t6_ready", dp_ready, 1);
        check("t6_rt_tag_hold", rt_tag, 4);
        drive(1, 5'd12, 0, 0, 0);
        check("t6_redispatch_count", rob_count, 1);
        drive(0, 0, 1, 3'd0, 32'hAB);
        check("t6_no_retire", rt_valid, 0);
        drive(0, 0, 0, 0, 0);
        check("t6_rt_valid_post", rt_valid, 1);
        check("t6_rt_pkt", {rt_tag, rt_r, rt_V}, {3'd0, 5'd12, 32'hAB});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
